mio_bus_bridge: RTL and testbench
=================================

# mio_bus_bridge

Memory/IO bus bridge sitting directly downstream of the multi-cycle CPU's memory port. It accepts the CPU's single outstanding bus request (breq, mem_w, address, write data), decodes the address to block RAM, a GPIO register pair or a free-running counter, performs the access, and returns read data with a one-cycle MIO_ready pulse that releases the CPU's wait state.

## Interface
Parameters:
- RAM_AW, 10, RAM word-address width (RAM size 2^RAM_AW words)
- RAM_LAT, 1, RAM read latency in cycles (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk)
- breq_i  in  1  CPU bus request (CPU breq_o)
- mem_w_i  in  1  1 = write, 0 = read (CPU mem_w)
- addr_i  in  32  byte address (CPU Addr_out)
- wdata_i  in  32  write data (CPU data_out)
- rdata_o  out  32  read data to CPU data_in
- mio_ready_o  out  1  access complete, one-cycle pulse
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  RAM_AW  RAM word address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data
- gpio_in_i  in  32  switch inputs
- gpio_out_o  out  32  LED output register
- bus_err_o  out  1  sticky unmapped-access flag

## Operation
- Address map (addr_i[31:28]): 0x0 → RAM, word address addr_i[RAM_AW+1:2]; 0xE → GPIO (read returns gpio_in_i, write loads gpio_out_o); 0xF → counter (read returns value, write loads it); anything else → unmapped.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: breq_i=1 at an edge → latch addr_i, wdata_i, mem_w_i, region; go ACCESS. Inputs ignored outside IDLE.
- ACCESS: RAM: ram_en_o=1, ram_we_o=latched mem_w; write → DONE, read → WAIT. GPIO/counter/unmapped: write committed and read value captured into rdata_o at end of cycle → DONE. Unmapped read captures 0; unmapped read or write sets bus_err_o.
- WAIT: lasts exactly RAM_LAT cycles; ram_rdata_i captured into rdata_o at end of the last → DONE.
- DONE: mio_ready_o=1 for this one cycle; → IDLE unconditionally. breq_i high in the following IDLE cycle is a new request (CPU advances on the ready cycle).
- rdata_o changes only on read capture; writes leave it unchanged.
- Counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF→0. A write loads wdata (no increment that cycle); the next cycle continues from the loaded value +1.
- bus_err_o cleared only by reset.
- ram_addr_o/ram_wdata_o driven from latched registers; ram_en_o/ram_we_o 0 outside ACCESS.

## Timing
- Request first sampled at edge E0 (breq_i high in cycle 0). ACCESS = cycle 1. mio_ready_o high in cycle 2 for RAM writes, GPIO, counter, unmapped; cycle 2+RAM_LAT for RAM reads. rdata_o valid in the ready cycle and held afterwards.
- Counter read returns value present during ACCESS cycle.
- Reset (reset=0 at an edge), including mid-access: state→IDLE, outstanding request dropped, no further RAM enable; rdata_o=0, mio_ready_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, gpio_out_o=0, counter=0, bus_err_o=0.
- mio_ready_o, ram_en_o, ram_we_o are decoded from registered state only (glitch-free).

## Structure
- Package mio_bus_pkg: region base nibbles (RAM 4'h0, GPIO 4'hE, CNT 4'hF), FSM state enum, unmapped read value 32'h0.
- One sub-module: mio_counter (32-bit load/increment counter with clk, reset, load_en, load_val, value).
- Bridge FSM, decode and capture registers in mio_bus_bridge; RAM is external.

## Test plan
- RAM write 0x0000_0010 ← 0x1234_5678 then read it (RAM_LAT=1) → ram_addr_o=4, ram_we_o=1 in write ACCESS; write ready in cycle 2, read ready in cycle 3 with rdata_o=0x1234_5678.
- Write 0xE000_0000 ← 0xA5A5_0000, read it with gpio_in_i=0x0000_00FF → gpio_out_o=0xA5A5_0000, read rdata_o=0x0000_00FF, ready in cycle 2 each.
- Counter write 0xFFFF_FFFE at 0xF000_0000, then read immediately → wrap verified; read value = 0xFFFF_FFFE + cycles elapsed, mod 2^32 (0x0000_0001 after 3 cycles).
- Read 0x8000_0000 → rdata_o=0, bus_err_o=1 and stays 1 through later valid accesses until reset.
- Back-to-back: breq_i held high across two requests → two distinct ready pulses, each in cycle 2 of its request, no access duplicated or lost; repeat with RAM_LAT=3 → read ready in cycle 5.
- reset=0 during WAIT → next cycle IDLE, mio_ready_o never pulses, all outputs at reset values; new request afterwards completes normally.

Source files
------------

// File: rtl/mio_bus_pkg.sv
// Shared definitions for the CPU memory/IO bus bridge: address map, FSM states and
// the region decode used when a request is latched.
package mio_bus_pkg;

    localparam logic [3:0]  RAM_BASE       = 4'h0;
    localparam logic [3:0]  GPIO_BASE      = 4'hE;
    localparam logic [3:0]  CNT_BASE       = 4'hF;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StDone
    } bridge_state_e;

    typedef enum logic [1:0] {
        RegRam,
        RegGpio,
        RegCnt,
        RegNone
    } region_e;

    function automatic region_e decode_region(input logic [3:0] nibble);
        region_e r;
        if (nibble == RAM_BASE) begin
            r = RegRam;
        end else if (nibble == GPIO_BASE) begin
            r = RegGpio;
        end else if (nibble == CNT_BASE) begin
            r = RegCnt;
        end else begin
            r = RegNone;
        end
        return r;
    endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit counter; a load replaces the increment for that cycle.
module mio_counter
    import mio_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [31:0] load_val,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    always_comb begin
        value_d = value_q + 32'd1;
        if (load_en) begin
            value_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= 32'h0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/mio_bus_bridge.sv
// Bridge between the CPU's single-outstanding memory port and block RAM, a GPIO
// register pair and a free-running counter; completes each access with a ready pulse.
module mio_bus_bridge
    import mio_bus_pkg::*;
#(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              breq_i,
    input  logic              mem_w_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              mio_ready_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic [31:0]       gpio_in_i,
    output logic [31:0]       gpio_out_o,
    output logic              bus_err_o
);

    localparam int unsigned WaitW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(RAM_LAT - 1);

    bridge_state_e     state_q, state_d;
    region_e           region_q;
    logic              we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       gpio_out_q;
    logic              bus_err_q;
    logic [WaitW-1:0]  wait_cnt_q;

    logic              capture_en;
    logic [31:0]       capture_val;
    logic              cnt_load;
    logic [31:0]       cnt_value;
    logic              req_accept;

    // Only the region nibble and the RAM word address are decoded.
    logic unused_addr;
    assign unused_addr = ^{addr_i[27:RAM_AW+2], addr_i[1:0]};

    assign req_accept = (state_q == StIdle) && breq_i;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (breq_i) state_d = StAccess;
            StAccess: state_d = (region_q == RegRam && !we_q) ? StWait : StDone;
            StWait:   if (wait_cnt_q == WaitLast) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only, so they cannot glitch.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        mio_ready_o = 1'b0;
        unique case (state_q)
            StAccess: begin
                ram_en_o = (region_q == RegRam);
                ram_we_o = (region_q == RegRam) && we_q;
            end
            StDone:   mio_ready_o = 1'b1;
            default:  ;
        endcase
    end

    // Read capture: IO regions in ACCESS, RAM at the end of the last WAIT cycle.
    always_comb begin
        capture_en  = 1'b0;
        capture_val = rdata_q;
        if (state_q == StAccess && !we_q) begin
            unique case (region_q)
                RegGpio: begin
                    capture_en  = 1'b1;
                    capture_val = gpio_in_i;
                end
                RegCnt: begin
                    capture_en  = 1'b1;
                    capture_val = cnt_value;
                end
                RegNone: begin
                    capture_en  = 1'b1;
                    capture_val = UNMAPPED_RDATA;
                end
                default: ;
            endcase
        end else if (state_q == StWait && wait_cnt_q == WaitLast) begin
            capture_en  = 1'b1;
            capture_val = ram_rdata_i;
        end
    end

    assign cnt_load = (state_q == StAccess) && (region_q == RegCnt) && we_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            region_q   <= RegRam;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            gpio_out_q <= 32'h0;
            bus_err_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            if (req_accept) begin
                region_q   <= decode_region(addr_i[31:28]);
                we_q       <= mem_w_i;
                ram_addr_q <= addr_i[RAM_AW+1:2];
                wdata_q    <= wdata_i;
            end
            if (state_q == StAccess) begin
                wait_cnt_q <= '0;
                if (region_q == RegGpio && we_q) begin
                    gpio_out_q <= wdata_q;
                end
                if (region_q == RegNone) begin
                    bus_err_q <= 1'b1;
                end
            end else if (state_q == StWait) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (capture_en) begin
                rdata_q <= capture_val;
            end
        end
    end

    mio_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .load_en  (cnt_load),
        .load_val (wdata_q),
        .value    (cnt_value)
    );

    assign rdata_o     = rdata_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = wdata_q;
    assign gpio_out_o  = gpio_out_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Directed bench for mio_bus_bridge: instance 0 uses RAM_LAT=1, instance 1 RAM_LAT=3,
// each with a behavioural RAM of matching latency.
module tb_mio_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        breq [2];
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] gpio_in;

    logic [31:0] rdata [2];
    logic        ready [2];
    logic        ram_en [2];
    logic        ram_we [2];
    logic [9:0]  ram_addr [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic [31:0] gpio_out [2];
    logic        bus_err [2];

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mio_bus_bridge #(.RAM_AW(10), .RAM_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .breq_i(breq[0]), .mem_w_i(mem_w), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata[0]), .mio_ready_o(ready[0]), .ram_en_o(ram_en[0]),
        .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
        .ram_rdata_i(ram_rdata[0]), .gpio_in_i(gpio_in), .gpio_out_o(gpio_out[0]),
        .bus_err_o(bus_err[0])
    );

    mio_bus_bridge #(.RAM_AW(10), .RAM_LAT(3)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .breq_i(breq[1]), .mem_w_i(mem_w), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata[1]), .mio_ready_o(ready[1]), .ram_en_o(ram_en[1]),
        .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
        .ram_rdata_i(ram_rdata[1]), .gpio_in_i(gpio_in), .gpio_out_o(gpio_out[1]),
        .bus_err_o(bus_err[1])
    );

    // Read data appears LAT cycles after the enable cycle.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem [1024];
        logic [31:0] pipe [L];
        always @(posedge clk) begin
            if (ram_en[g] && ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
            if (ram_en[g] && !ram_we[g]) pipe[0] <= mem[ram_addr[g]];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_rdata[g] = pipe[L-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One request: breq high for cycle 0 only; returns once mio_ready_o is seen.
    task automatic run_req(input int sel, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] gin,
                           input int exp_lat, input string tag);
        int lat = -1;
        logic is_ram = (a[31:28] == 4'h0);
        for (int k = 0; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, " ram_en"}, 32'(ram_en[sel]), 32'(is_ram));
                chk({tag, " ram_we"}, 32'(ram_we[sel]), 32'(is_ram && we));
                if (is_ram) begin
                    chk({tag, " ram_addr"}, 32'(ram_addr[sel]), 32'(a[11:2]));
                    if (we) chk({tag, " ram_wdata"}, ram_wdata[sel], wd);
                end
            end
            if (k > 0 && ready[sel]) lat = k;
            if (k == 0) begin
                breq[sel] = 1'b1;
                mem_w     = we;
                addr      = a;
                wdata     = wd;
                gpio_in   = gin;
            end
            if (k == 1) breq[sel] = 1'b0;
        end
        breq[sel] = 1'b0;
        chk({tag, " ready_cycle"}, 32'(lat), 32'(exp_lat));
    endtask

    // breq held high across a write then a read of the same address.
    task automatic run_b2b(input int sel, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] gin, input logic [15:0] exp_mask,
                           input string tag);
        logic [15:0] mask = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            mask[k] = ready[sel];
            if (k == 0) begin
                breq[sel] = 1'b1;
                mem_w     = 1'b1;
                addr      = a;
                wdata     = wd;
                gpio_in   = gin;
            end
            if (k == 1) mem_w = 1'b0;
            if (k == 4) breq[sel] = 1'b0;
        end
        chk({tag, " ready_pattern"}, 32'(mask), 32'(exp_mask));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] gin;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] gpio;
        logic        err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic hit;
        vecs[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,  2, 32'h0,         32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,  3, 32'h1234_5678, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 32'hE000_0000, 32'hA5A5_0000, 32'hFF, 2, 32'h1234_5678, 32'hA5A5_0000, 1'b0};
        vecs[3] = '{1'b0, 32'hE000_0000, 32'h0,         32'hFF, 2, 32'h0000_00FF, 32'hA5A5_0000, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0,  2, 32'h0000_00FF, 32'hA5A5_0000, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0,  3, 32'hDEAD_BEEF, 32'hA5A5_0000, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,  2, 32'h0,         32'hA5A5_0000, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,  3, 32'h1234_5678, 32'hA5A5_0000, 1'b1};
        vecs[8] = '{1'b1, 32'h2000_0000, 32'h5555_5555, 32'h0,  2, 32'h1234_5678, 32'hA5A5_0000, 1'b1};
        // 0x1010 aliases word 4 with a 10-bit word address
        vecs[9] = '{1'b0, 32'h0000_1010, 32'h0,         32'h0,  3, 32'h1234_5678, 32'hA5A5_0000, 1'b1};

        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        breq[0]  = 1'b0; breq[1]  = 1'b0;
        mem_w = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset rdata",    rdata[s],           32'h0);
            chk("reset ready",    32'(ready[s]),      32'h0);
            chk("reset ram_en",   32'(ram_en[s]),     32'h0);
            chk("reset ram_addr", 32'(ram_addr[s]),   32'h0);
            chk("reset gpio_out", gpio_out[s],        32'h0);
            chk("reset bus_err",  32'(bus_err[s]),    32'h0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int i = 0; i < 10; i++) begin
            string tag = $sformatf("vec%0d", i);
            run_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gin, vecs[i].lat, tag);
            chk({tag, " rdata"},    rdata[0],          vecs[i].rdata);
            chk({tag, " gpio_out"}, gpio_out[0],       vecs[i].gpio);
            chk({tag, " bus_err"},  32'(bus_err[0]),   32'(vecs[i].err));
        end

        // Load 0xFFFFFFFE (value present in DONE cycle D); the next read's ACCESS is D+2,
        // giving FFFFFFFE+2 = 0; the read after that has ACCESS at D+5 -> 3.
        run_req(0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'h0, 2, "cnt_load");
        chk("cnt_load rdata_held", rdata[0], 32'h1234_5678);
        run_req(0, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 2, "cnt_rd1");
        chk("cnt_rd1 wrapped", rdata[0], 32'h0000_0000);
        run_req(0, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 2, "cnt_rd2");
        chk("cnt_rd2 value", rdata[0], 32'h0000_0003);

        run_b2b(0, 32'hE000_0004, 32'h0000_0011, 32'h0000_0F0F, 16'h0024, "b2b_gpio");
        chk("b2b_gpio gpio_out", gpio_out[0], 32'h0000_0011);
        chk("b2b_gpio rdata",    rdata[0],    32'h0000_0F0F);

        // RAM_LAT=3: unmapped read to set the error flag, then back-to-back RAM write/read.
        run_req(1, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 2, "lat3_unmapped");
        chk("lat3_unmapped bus_err", 32'(bus_err[1]), 32'h1);
        run_b2b(1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 16'h0104, "b2b_ram3");
        chk("b2b_ram3 rdata", rdata[1], 32'hCAFE_F00D);

        // Reset while the read sits in WAIT.
        hit = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (ready[1]) hit = 1'b1;
            if (k >= 3 && ram_en[1]) hit = 1'b1;
            if (k == 2) chk("rst_wait in_wait_no_en", 32'(ram_en[1]), 32'h0);
            if (k == 3) begin
                chk("rst_wait rdata",     rdata[1],         32'h0);
                chk("rst_wait bus_err",   32'(bus_err[1]),  32'h0);
                chk("rst_wait ram_addr",  32'(ram_addr[1]), 32'h0);
                chk("rst_wait ram_wdata", ram_wdata[1],     32'h0);
                chk("rst_wait gpio_out",  gpio_out[1],      32'h0);
                rst_n[1] = 1'b1;
            end
            if (k == 0) begin
                breq[1] = 1'b1; mem_w = 1'b0; addr = 32'h0000_0040;
            end
            if (k == 1) breq[1] = 1'b0;
            if (k == 2) rst_n[1] = 1'b0;
        end
        chk("rst_wait no_ready_or_en", 32'(hit), 32'h0);
        run_req(1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 5, "post_rst_rd");
        chk("post_rst_rd rdata",   rdata[1],        32'hCAFE_F00D);
        chk("post_rst_rd bus_err", 32'(bus_err[1]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
